div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 168 ++++++++++++++++
 tb/tb_div_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Button-driven operand entry and result display sequencer for an external divider.
// Optional divider watchdog enabled by defining DIV_TIMEOUT_EN.
module div_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_inc,
    input  logic             btn_next,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] led,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        LOAD_NUM = 3'd0,
        LOAD_DEN = 3'd1,
        RUN      = 3'd2,
        SHOW_Q   = 3'd3,
        SHOW_R   = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] r_reg_q, r_reg_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             start_q, start_d;
    logic             timeout_hit;

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        q_reg_d = q_reg_q;
        r_reg_d = r_reg_q;
        start_d = 1'b0;
`ifdef DIV_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (btn_clr) begin
            state_d = LOAD_NUM;
            num_d   = '0;
            den_d   = '0;
            q_reg_d = '0;
            r_reg_d = '0;
        end else begin
            case (state_q)
                LOAD_NUM: begin
                    if (btn_next) begin
                        state_d = LOAD_DEN;
                    end else if (btn_inc) begin
                        num_d = num_q + 1'b1;
                    end
                end
                LOAD_DEN: begin
                    if (btn_next) begin
                        if (den_q != '0) begin
                            state_d = RUN;
                            start_d = 1'b1;
`ifdef DIV_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end else begin
                            state_d = ERR;
                        end
                    end else if (btn_inc) begin
                        den_d = den_q + 1'b1;
                    end
                end
                RUN: begin
                    // A result arriving on the last watchdog cycle still counts.
                    if (div_done) begin
                        q_reg_d = div_q;
                        r_reg_d = div_r;
                        state_d = SHOW_Q;
                    end else if (timeout_hit) begin
                        state_d = ERR;
                    end else begin
`ifdef DIV_TIMEOUT_EN
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
                SHOW_Q: begin
                    if (btn_next) begin
                        state_d = SHOW_R;
                    end
                end
                SHOW_R, ERR: begin
                    if (btn_next) begin
                        state_d = LOAD_NUM;
                        num_d   = '0;
                        den_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_NUM;
                end
            endcase
        end
    end

    // The display register follows the next-state view so it settles with the state.
    always_comb begin
        led_d = '0;
        case (state_d)
            LOAD_NUM: led_d = num_d;
            LOAD_DEN: led_d = den_d;
            RUN:      led_d = '0;
            SHOW_Q:   led_d = q_reg_d;
            SHOW_R:   led_d = r_reg_d;
            ERR:      led_d = '1;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_NUM;
            num_q   <= '0;
            den_q   <= '0;
            q_reg_q <= '0;
            r_reg_q <= '0;
            led_q   <= '0;
            start_q <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            q_reg_q <= q_reg_d;
            r_reg_q <= r_reg_d;
            led_q   <= led_d;
            start_q <= start_d;
`ifdef DIV_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign div_num   = num_q;
    assign div_den   = den_q;
    assign div_start = start_q;
    assign led       = led_q;
    assign state     = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with hand-computed expectations.
// Also exercises the watchdog path when built with DIV_TIMEOUT_EN.
module tb_div_sequencer;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 32;

    logic             clk;
    logic             rst_n;
    logic             btn_inc;
    logic             btn_next;
    logic             btn_clr;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] led;
    logic [2:0]       state;

    int checks;
    int errors;
    int start_count;

    div_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_inc   (btn_inc),
        .btn_next  (btn_next),
        .btn_clr   (btn_clr),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_start (div_start),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r),
        .led       (led),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle in which the start pulse is seen by the divider.
    always @(posedge clk) begin
        if (div_start) start_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic nxt, input logic clr);
        @(negedge clk);
        btn_inc  = inc;
        btn_next = nxt;
        btn_clr  = clr;
        @(negedge clk);
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic finishDivide(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        @(negedge clk);
        div_done = 1'b1;
        div_q    = q;
        div_r    = r;
        @(negedge clk);
        div_done = 1'b0;
        div_q    = '0;
        div_r    = '0;
    endtask

    initial begin
        int starts_before;
        checks      = 0;
        errors      = 0;
        start_count = 0;
        rst_n       = 1'b0;
        btn_inc     = 1'b0;
        btn_next    = 1'b0;
        btn_clr     = 1'b0;
        div_done    = 1'b0;
        div_q       = '0;
        div_r       = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_state", state, 0);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_num", div_num, 0);
        checkOutput("reset_start", div_start, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2 / 1 -> q=2 r=0
        pressInc(2);
        checkOutput("t1_led_num", led, 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1_state_den", state, 1);
        pressInc(1);
        checkOutput("t1_led_den", led, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1_start_hi", div_start, 1);
        checkOutput("t1_num", div_num, 2);
        checkOutput("t1_den", div_den, 1);
        checkOutput("t1_led_run", led, 0);
        @(negedge clk);
        checkOutput("t1_start_lo", div_start, 0);
        pressInc(2);
        checkOutput("t1_run_ignore_inc", div_num, 2);
        finishDivide(4'd2, 4'd0);
        checkOutput("t1_state_q", state, 3);
        checkOutput("t1_led_q", led, 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1_state_r", state, 4);
        checkOutput("t1_led_r", led, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1_state_back", state, 0);
        checkOutput("t1_led_back", led, 0);
        checkOutput("t1_num_back", div_num, 0);
        checkOutput("t1_start_count", start_count, 1);

        // 7 / 2 -> q=3 r=1
        pressInc(7);
        checkOutput("t2_led_num", led, 7);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_state_run", state, 2);
        finishDivide(4'd3, 4'd1);
        checkOutput("t2_state_q", state, 3);
        checkOutput("t2_led_q", led, 3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_state_r", state, 4);
        checkOutput("t2_led_r", led, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // 5 / 0 -> ERR without a start pulse
        starts_before = start_count;
        pressInc(5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_state_err", state, 5);
        checkOutput("t3_led_err", led, 15);
        checkOutput("t3_no_start", start_count, starts_before);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_state_back", state, 0);
        checkOutput("t3_num_back", div_num, 0);

        // Wrap and button priority
        pressInc(16);
        checkOutput("t4_wrap_num", div_num, 0);
        checkOutput("t4_wrap_led", led, 0);
        pressInc(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_incnext_state", state, 1);
        checkOutput("t4_incnext_num", div_num, 3);
        checkOutput("t4_incnext_den", div_den, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_clr_state", state, 0);
        checkOutput("t4_clr_num", div_num, 0);
        finishDivide(4'd9, 4'd9);
        checkOutput("t4_done_ignored", state, 0);

        // Abort a run, then a late result arrives
        pressInc(6);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5_clr_state", state, 0);
        finishDivide(4'd2, 4'd1);
        checkOutput("t5_late_state", state, 0);
        checkOutput("t5_late_led", led, 0);
        checkOutput("t5_q_reg", dut.q_reg_q, 0);
        checkOutput("t5_r_reg", dut.r_reg_q, 0);

        // Asynchronous reset in the middle of a run
        pressInc(4);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_state", state, 0);
        checkOutput("t6_rst_num", div_num, 0);
        checkOutput("t6_rst_den", div_den, 0);
        checkOutput("t6_rst_led", led, 0);
        checkOutput("t6_rst_start", div_start, 0);
        starts_before = start_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t6_no_restart", start_count, starts_before);
        checkOutput("t6_state_idle", state, 0);

        // Divider never answers
        pressInc(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef DIV_TIMEOUT_EN
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("t7_still_run", state, 2);
        @(negedge clk);
        checkOutput("t7_timeout_err", state, 5);
        checkOutput("t7_timeout_led", led, 15);
`else
        repeat (1000) @(negedge clk);
        checkOutput("t7_still_run", state, 2);
        checkOutput("t7_run_led", led, 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t7_clr_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
